// File: rtl/axrm_pkg.sv
// Shared constants and the approximate 2x2 product used by every partial-product cell.
package axrm_pkg;

  // Number of register stages between operand acceptance and result.
  localparam int unsigned AXRM_LAT = 3;

  // Operand group width and the width of one group product.
  localparam int unsigned GRP_W = 2;
  localparam int unsigned PP_W  = 2 * GRP_W;

  // Exact 2x2 product except 3x3, which collapses to 7 so the result fits in three bits.
  function automatic logic [PP_W-1:0] approx_mul2(input logic [GRP_W-1:0] x,
                                                  input logic [GRP_W-1:0] y);
    logic [PP_W-1:0] p;
    p = PP_W'(x) * PP_W'(y);
    if ((x == '1) && (y == '1)) begin
      p = PP_W'(7);
    end
    return p;
  endfunction

endpackage

// File: rtl/axrm_pipe_if.sv
// Operand/result stream bundle for the approximate multiplier pipeline.
interface axrm_pipe_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned TW = $clog2(2 * (W / 2))
);
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic              approx_en;
  logic [TW-1:0]     thresh;
  logic              out_valid;
  logic              out_ready;
  logic [2*W-1:0]    result;
  logic              approx_hit;

  // Producer/consumer side of the pipeline.
  modport master (
    output in_valid, a, b, approx_en, thresh, out_ready,
    input  in_ready, out_valid, result, approx_hit
  );

  // The pipeline itself.
  modport slave (
    input  in_valid, a, b, approx_en, thresh, out_ready,
    output in_ready, out_valid, result, approx_hit
  );
endinterface

// File: rtl/axrm_pp2.sv
// One 2x2 partial-product cell with selectable approximation.
module axrm_pp2
  import axrm_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             approx,
  output logic [PP_W-1:0]  prod,
  output logic             hit
);

  // Pick exact or approximate product; flag when approximation changed the value.
  always_comb begin
    prod = PP_W'(a) * PP_W'(b);
    hit  = 1'b0;
    if (approx) begin
      prod = approx_mul2(a, b);
      hit  = (a == '1) && (b == '1);
    end
  end

endmodule

// File: rtl/axrm_pipe.sv
// Three-stage approximate unsigned multiplier with a global-stall stream handshake.
module axrm_pipe
  import axrm_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned TW = $clog2(2 * (W / 2)),
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  axrm_pipe_if.slave    bus,
  input  logic          hit_clr,
  output logic [CW-1:0] hit_cnt
);

  localparam int N  = int'(W) / 2;
  localparam int NN = N * N;
  localparam int RW = 2 * int'(W);

  logic adv;
  logic fire;

  // Whole pipe moves together; it only freezes when a result is waiting.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign fire         = bus.out_valid && bus.out_ready;

  // S1: operands and config captured together so config travels with the beat.
  logic          s1_valid;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  logic          s1_en;
  logic [TW-1:0] s1_thresh;

  // Stage 1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_en     <= 1'b0;
      s1_thresh <= '0;
    end else if (adv) begin
      s1_valid  <= bus.in_valid;
      s1_a      <= bus.a;
      s1_b      <= bus.b;
      s1_en     <= bus.approx_en;
      s1_thresh <= bus.thresh;
    end
  end

  // Partial-product array; cell (i,j) carries weight 4^(i+j).
  logic [NN-1:0][PP_W-1:0] pp;
  logic [NN-1:0]           pp_hit;

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic sel;
      // Low-weight cells are approximated when their weight index is below thresh.
      assign sel = s1_en && ((gi + gj) < int'(s1_thresh));
      axrm_pp2 u_pp2 (
        .a      (s1_a[GRP_W*gi +: GRP_W]),
        .b      (s1_b[GRP_W*gj +: GRP_W]),
        .approx (sel),
        .prod   (pp[gi*N+gj]),
        .hit    (pp_hit[gi*N+gj])
      );
    end
  end

  // S2: partial products.
  logic                    s2_valid;
  logic [NN-1:0][PP_W-1:0] s2_pp;
  logic [NN-1:0]           s2_hit;

  // Stage 2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_pp    <= '0;
      s2_hit   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_pp    <= pp;
      s2_hit   <= pp_hit;
    end
  end

  logic [RW-1:0] sum_d;
  logic          hit_d;

  // Weighted reduction of the partial products at full 2W precision.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sum_d = sum_d + (RW'(s2_pp[i*N+j]) << (2 * (i + j)));
      end
    end
    hit_d = |s2_hit;
  end

  // Stage 3 register drives the result beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.result     <= '0;
      bus.approx_hit <= 1'b0;
    end else if (adv) begin
      bus.out_valid  <= s2_valid;
      bus.result     <= sum_d;
      bus.approx_hit <= hit_d;
    end
  end

  // Saturating count of delivered approximate beats; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (hit_clr) begin
      hit_cnt <= '0;
    end else if (fire && bus.approx_hit && (hit_cnt != '1)) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_axrm_pipe.sv
// Directed bench for axrm_pipe: latency, approximation corners, streaming, stall, counter, reset.
module tb_axrm_pipe;
  import axrm_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned TW = 3;
  localparam int unsigned CW = 2;
  localparam int          RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hit_clr = 1'b0;
  logic [CW-1:0] hit_cnt;

  int checks = 0;
  int errors = 0;

  logic [RW:0] exp_q[$];
  int          n_in;
  int          n_out;
  bit          accepted;
  logic [RW-1:0] held;

  axrm_pipe_if #(.W(W), .TW(TW)) bus ();

  axrm_pipe #(.W(W), .TW(TW), .CW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .hit_clr (hit_clr),
    .hit_cnt (hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Exact product minus 2*4^(i+j) for every approximated 3x3 group pair (9 - 7 = 2).
  function automatic logic [RW:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic en, input logic [TW-1:0] th);
    logic [RW-1:0] p;
    logic [1:0]    ga;
    logic [1:0]    gb;
    logic          h;
    p = RW'(a) * RW'(b);
    h = 1'b0;
    for (int i = 0; i < W / 2; i++) begin
      for (int j = 0; j < W / 2; j++) begin
        ga = a[2*i +: 2];
        gb = b[2*j +: 2];
        if (en && ((i + j) < int'(th)) && (ga == 2'd3) && (gb == 2'd3)) begin
          p = p - (RW'(2) << (2 * (i + j)));
          h = 1'b1;
        end
      end
    end
    return {h, p};
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic en,
                       input logic [TW-1:0] th);
    bus.a         = a;
    bus.b         = b;
    bus.approx_en = en;
    bus.thresh    = th;
  endtask

  task automatic drive_rand();
    drive(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), TW'($urandom_range(0, 7)));
  endtask

  // One cycle of the streaming scoreboard; called at a negedge after inputs are set.
  task automatic tick();
    logic [RW:0] e;
    #1;
    accepted = 1'b0;
    if (bus.out_valid && bus.out_ready) begin
      check("stream_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("stream_result", 32'(bus.result), 32'(e[RW-1:0]));
        check("stream_hit", 32'(bus.approx_hit), 32'(e[RW]));
        n_out++;
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(bus.a, bus.b, bus.approx_en, bus.thresh));
      n_in++;
      accepted = 1'b1;
    end
    @(negedge clk);
  endtask

  // Single beat into an empty pipe; checks exact latency and the delivered value.
  task automatic send_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic en, input logic [TW-1:0] th,
                          input logic [RW-1:0] exp_res, input logic exp_hit,
                          input bit clr_on_out);
    drive(a, b, en, th);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int c = 1; c < int'(AXRM_LAT); c++) begin
      check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    check({tag, "_hit"}, 32'(bus.approx_hit), 32'(exp_hit));
    hit_clr = clr_on_out;
    @(negedge clk);
    hit_clr = 1'b0;
    check({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive('0, '0, 1'b0, '0);

    // Reset state.
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_hit", 32'(bus.approx_hit), 32'd0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed corners.
    send_one("exact_ff", 8'hFF, 8'hFF, 1'b0, 3'd0, 16'hFE01, 1'b0, 1'b0);
    check("cnt_after_exact", 32'(hit_cnt), 32'd0);
    send_one("apx_t7", 8'hFF, 8'hFF, 1'b1, 3'd7, 16'hC58F, 1'b1, 1'b0);
    check("cnt_after_t7", 32'(hit_cnt), 32'd1);
    send_one("apx_t1", 8'hFF, 8'hFF, 1'b1, 3'd1, 16'hFDFF, 1'b1, 1'b0);
    send_one("apx_t0", 8'hFF, 8'hFF, 1'b1, 3'd0, 16'hFE01, 1'b0, 1'b0);
    send_one("apx_mix", 8'hC3, 8'h0F, 1'b1, 3'd3, 16'h0B63, 1'b1, 1'b0);
    check("cnt_after_mix", 32'(hit_cnt), 32'd3);

    // Counter clear, saturation, and clear winning over a simultaneous hit.
    hit_clr = 1'b1;
    @(negedge clk);
    hit_clr = 1'b0;
    check("cnt_clear", 32'(hit_cnt), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      send_one("sat_beat", 8'h03, 8'h03, 1'b1, 3'd1, 16'h0007, 1'b1, 1'b0);
      check("cnt_sat", 32'(hit_cnt), 32'((k > 3) ? 3 : k));
    end
    send_one("clr_hit", 8'h03, 8'h03, 1'b1, 3'd1, 16'h0007, 1'b1, 1'b1);
    check("cnt_clr_prio", 32'(hit_cnt), 32'd0);

    // Back-to-back stream of 20 beats.
    exp_q.delete();
    n_in  = 0;
    n_out = 0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive_rand();
      bus.in_valid = 1'b1;
      tick();
      check("stream_accept", 32'(accepted), 32'd1);
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < int'(AXRM_LAT); k++) tick();
    check("stream_count", 32'(n_out), 32'd20);
    check("stream_idle", 32'(bus.out_valid), 32'd0);

    // Five-cycle output stall mid-stream.
    exp_q.delete();
    n_in  = 0;
    n_out = 0;
    drive_rand();
    bus.in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      bus.out_ready = !((c >= 5) && (c < 10));
      if (!bus.out_ready) begin
        #1;
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        if (c == 5) held = bus.result;
        else check("stall_hold", 32'(bus.result), 32'(held));
      end
      tick();
      if (c >= 11) bus.in_valid = 1'b0;
      else if (accepted) drive_rand();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10 && n_out < n_in; k++) tick();
    check("stall_in_count", 32'(n_in), 32'd7);
    check("stall_out_count", 32'(n_out), 32'(n_in));
    check("stall_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset with three beats in flight.
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(8'hFF, 8'(k + 1), 1'b1, 3'd7);
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_result", 32'(bus.result), 32'd0);
    check("mid_rst_hit", 32'(bus.approx_hit), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_cnt", 32'(hit_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_stale", 32'(bus.out_valid), 32'd0);
    end
    send_one("post_rst", 8'h12, 8'h34, 1'b0, 3'd0, 16'h03A8, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
